// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand path.
//   - 4-bit opcode encodings consumed by operand_map and alu_operand_stage
//   - reserved opcode prefix (ops 11xx pass through flagged as illegal)
//   - payload_width(): bits in one mapped transaction
//     {amod[W], bmod[W], cin, op[4], illegal}
package alu_pkg;

    localparam logic [3:0] OP_PASSA  = 4'b0000;
    localparam logic [3:0] OP_NEG    = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_INC    = 4'b0011;
    // 4'b01xx are logic ops: operands pass straight through
    localparam logic [3:0] OP_SUB    = 4'b1000;
    localparam logic [3:0] OP_DEC    = 4'b1001;
    localparam logic [3:0] OP_ACCADD = 4'b1010;
    localparam logic [3:0] OP_ACCSUB = 4'b1011;

    localparam logic [1:0] OP_RSVD_PREFIX = 2'b11;

    function automatic int payload_width(input int width);
        return width * 2 + 6;
    endfunction

endpackage

// File: rtl/operand_map.sv
// Combinational opcode decoder: turns op plus operands A/B (and the
// accumulator value) into adder-ready operands.
// Ports:
//   op      in  4      opcode
//   a, b    in  WIDTH  raw operands
//   acc     in  WIDTH  accumulator value (already forwarded by the caller)
//   amod    out WIDTH  adder operand A
//   bmod    out WIDTH  adder operand B
//   cin     out 1      adder carry-in
//   illegal out 1      op is in the reserved 11xx range
module operand_map
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] amod,
    output logic [WIDTH-1:0] bmod,
    output logic             cin,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] K1 = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        // Default is the plain a/b pass-through used by ADD, logic ops and
        // reserved ops.
        amod    = a;
        bmod    = b;
        cin     = 1'b0;
        illegal = 1'b0;
        if (op[3:2] == OP_RSVD_PREFIX) begin
            illegal = 1'b1;
        end else begin
            case (op)
                OP_PASSA: begin
                    amod = '0;
                    bmod = a;
                end
                OP_NEG: begin
                    // -a = ~a + 1, the +1 supplied through amod
                    amod = K1;
                    bmod = ~a;
                end
                OP_INC: begin
                    amod = K1;
                    bmod = a;
                end
                OP_SUB: begin
                    bmod = ~b;
                    cin  = 1'b1;
                end
                OP_DEC: begin
                    bmod = '1;
                end
                OP_ACCADD: begin
                    amod = acc;
                end
                OP_ACCSUB: begin
                    amod = acc;
                    bmod = ~b;
                    cin  = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Pipelined ALU operand stage: maps op/a/b onto adder operands and
// registers them behind a valid/ready handshake with an output register
// plus one skid entry. Holds the accumulator used by ACC ops.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake (in_ready = skid empty)
//   a, b, op             raw operands and opcode
//   acc_wr, acc_din      accumulator load
//   out_valid/out_ready  downstream handshake
//   amod, bmod, cin      mapped adder operands
//   op_q, illegal        opcode travelling with the data, reserved-op flag
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             acc_wr,
    input  logic [WIDTH-1:0] acc_din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] amod,
    output logic [WIDTH-1:0] bmod,
    output logic             cin,
    output logic [3:0]       op_q,
    output logic             illegal
);

    localparam int PW = payload_width(WIDTH);

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] map_amod;
    logic [WIDTH-1:0] map_bmod;
    logic             map_cin;
    logic             map_illegal;
    logic [PW-1:0]    in_payload;
    logic [PW-1:0]    skid_reg;
    logic [PW-1:0]    out_reg;
    logic             skid_valid_reg;
    logic             out_valid_reg;
    logic             accept;
    logic             out_free;

    // An ACC op accepted in the same cycle as a load sees the new value.
    assign acc_eff = acc_wr ? acc_din : acc_reg;

    operand_map #(.WIDTH(WIDTH)) u_map (
        .op      (op),
        .a       (a),
        .b       (b),
        .acc     (acc_eff),
        .amod    (map_amod),
        .bmod    (map_bmod),
        .cin     (map_cin),
        .illegal (map_illegal)
    );

    // Mapping happens at acceptance, so the skid holds finished payloads and
    // later accumulator writes cannot disturb a buffered ACC op.
    assign in_payload = {map_amod, map_bmod, map_cin, op, map_illegal};

    assign in_ready  = ~skid_valid_reg;
    assign accept    = in_valid & in_ready;
    assign out_free  = ~out_valid_reg | out_ready;
    assign out_valid = out_valid_reg;
    assign {amod, bmod, cin, op_q, illegal} = out_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg        <= '0;
            skid_reg       <= '0;
            out_reg        <= '0;
            skid_valid_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
        end else begin
            if (acc_wr) begin
                acc_reg <= acc_din;
            end
            if (out_free) begin
                // Skid is older than anything on the input, so it goes first.
                // in_ready is low while the skid is full, so no accept can
                // coincide with the skid transfer.
                if (skid_valid_reg) begin
                    out_reg        <= skid_reg;
                    out_valid_reg  <= 1'b1;
                    skid_valid_reg <= 1'b0;
                end else if (accept) begin
                    out_reg       <= in_payload;
                    out_valid_reg <= 1'b1;
                end else begin
                    out_valid_reg <= 1'b0;
                end
            end else if (accept) begin
                // Output held: park the new transaction in the skid entry.
                skid_reg       <= in_payload;
                skid_valid_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       acc_wr;
    logic [7:0] acc_din;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] amod;
    logic [7:0] bmod;
    logic       cin;
    logic [3:0] op_q;
    logic       illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_wr    (acc_wr),
        .acc_din   (acc_din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .amod      (amod),
        .bmod      (bmod),
        .cin       (cin),
        .op_q      (op_q),
        .illegal   (illegal)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb);
        in_valid = 1'b1;
        op = o;
        a  = va;
        b  = vb;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; acc_wr = 1'b0;
        acc_din = 8'h00; a = 8'h00; b = 8'h00; op = 4'h0;
        tick(); tick();
        reset = 1'b0;
        $display("tb: reset applied");
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (amod !== 8'h00) begin errors++; $display("FAIL reset_amod got=%h exp=00", amod); end
        checks++; if (bmod !== 8'h00) begin errors++; $display("FAIL reset_bmod got=%h exp=00", bmod); end
        checks++; if (cin !== 1'b0) begin errors++; $display("FAIL reset_cin got=%b exp=0", cin); end
        checks++; if (op_q !== 4'h0) begin errors++; $display("FAIL reset_op_q got=%h exp=0", op_q); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    endtask

    // Single transactions with out_ready=1, one per table row.
    task automatic test_mapping();
        logic [3:0] t_op [8];
        logic [7:0] t_a  [8];
        logic [7:0] t_b  [8];
        logic [7:0] e_am [8];
        logic [7:0] e_bm [8];
        logic       e_ci [8];
        t_op[0]=4'b1000; t_a[0]=8'h05; t_b[0]=8'h03; e_am[0]=8'h05; e_bm[0]=8'hFC; e_ci[0]=1'b1; // SUB
        t_op[1]=4'b0001; t_a[1]=8'h05; t_b[1]=8'h77; e_am[1]=8'h01; e_bm[1]=8'hFA; e_ci[1]=1'b0; // NEG
        t_op[2]=4'b0011; t_a[2]=8'hFF; t_b[2]=8'h77; e_am[2]=8'h01; e_bm[2]=8'hFF; e_ci[2]=1'b0; // INC
        t_op[3]=4'b0000; t_a[3]=8'h42; t_b[3]=8'h99; e_am[3]=8'h00; e_bm[3]=8'h42; e_ci[3]=1'b0; // PASSA
        t_op[4]=4'b0010; t_a[4]=8'hA0; t_b[4]=8'h0B; e_am[4]=8'hA0; e_bm[4]=8'h0B; e_ci[4]=1'b0; // ADD
        t_op[5]=4'b1001; t_a[5]=8'h10; t_b[5]=8'h22; e_am[5]=8'h10; e_bm[5]=8'hFF; e_ci[5]=1'b0; // DEC
        t_op[6]=4'b0101; t_a[6]=8'h0F; t_b[6]=8'hF0; e_am[6]=8'h0F; e_bm[6]=8'hF0; e_ci[6]=1'b0; // logic
        t_op[7]=4'b1000; t_a[7]=8'h00; t_b[7]=8'h00; e_am[7]=8'h00; e_bm[7]=8'hFF; e_ci[7]=1'b1; // SUB 0-0
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(t_op[i], t_a[i], t_b[i]);
            tick();
            in_valid = 1'b0;
            $display("tb: map op=%b a=%h b=%h -> amod=%h bmod=%h cin=%b", t_op[i], t_a[i], t_b[i], amod, bmod, cin);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL map%0d_valid got=%b exp=1", i, out_valid); end
            checks++; if (amod !== e_am[i]) begin errors++; $display("FAIL map%0d_amod got=%h exp=%h", i, amod, e_am[i]); end
            checks++; if (bmod !== e_bm[i]) begin errors++; $display("FAIL map%0d_bmod got=%h exp=%h", i, bmod, e_bm[i]); end
            checks++; if (cin !== e_ci[i]) begin errors++; $display("FAIL map%0d_cin got=%b exp=%b", i, cin, e_ci[i]); end
            checks++; if (op_q !== t_op[i]) begin errors++; $display("FAIL map%0d_op_q got=%b exp=%b", i, op_q, t_op[i]); end
            checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL map%0d_illegal got=%b exp=0", i, illegal); end
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL map%0d_drain got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(4'b0010, 8'h01, 8'h02);
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_first got=%b exp=1", in_ready); end
        drive(4'b0010, 8'h03, 8'h04);
        tick();
        $display("tb: bp two accepted, in_ready=%b amod=%h bmod=%h", in_ready, amod, bmod);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
        drive(4'b0010, 8'h05, 8'h06);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || amod !== 8'h01 || bmod !== 8'h02) begin
                errors++; $display("FAIL bp_hold%0d got=%b/%h/%h exp=1/01/02", i, out_valid, amod, bmod);
            end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall%0d got=%b exp=0", i, in_ready); end
        end
        out_ready = 1'b1;
        tick();
        $display("tb: bp drain1 amod=%h bmod=%h", amod, bmod);
        checks++; if (out_valid !== 1'b1 || amod !== 8'h03 || bmod !== 8'h04) begin
            errors++; $display("FAIL bp_second got=%b/%h/%h exp=1/03/04", out_valid, amod, bmod);
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_free got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        $display("tb: bp drain2 amod=%h bmod=%h", amod, bmod);
        checks++; if (out_valid !== 1'b1 || amod !== 8'h05 || bmod !== 8'h06) begin
            errors++; $display("FAIL bp_third got=%b/%h/%h exp=1/05/06", out_valid, amod, bmod);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_accumulator();
        out_ready = 1'b1;
        acc_wr = 1'b1; acc_din = 8'h10;
        drive(4'b1010, 8'h99, 8'h02);
        tick();
        acc_wr = 1'b0;
        $display("tb: accadd fwd amod=%h bmod=%h", amod, bmod);
        checks++; if (amod !== 8'h10 || bmod !== 8'h02 || cin !== 1'b0) begin
            errors++; $display("FAIL acc_fwd got=%h/%h/%b exp=10/02/0", amod, bmod, cin);
        end
        drive(4'b1010, 8'h99, 8'h03);
        tick();
        checks++; if (amod !== 8'h10 || bmod !== 8'h03) begin
            errors++; $display("FAIL acc_held got=%h/%h exp=10/03", amod, bmod);
        end
        drive(4'b1011, 8'h99, 8'h01);
        tick();
        in_valid = 1'b0;
        $display("tb: accsub amod=%h bmod=%h cin=%b", amod, bmod, cin);
        checks++; if (amod !== 8'h10 || bmod !== 8'hFE || cin !== 1'b1) begin
            errors++; $display("FAIL acc_sub got=%h/%h/%b exp=10/FE/1", amod, bmod, cin);
        end
        tick();
        // Buffered ACC op keeps its captured value despite later writes.
        out_ready = 1'b0;
        drive(4'b1010, 8'h00, 8'h00);
        tick();
        acc_wr = 1'b1; acc_din = 8'h20;
        drive(4'b1010, 8'h00, 8'h00);
        tick();
        in_valid = 1'b0; acc_din = 8'h30;
        tick();
        acc_wr = 1'b0;
        checks++; if (amod !== 8'h10) begin errors++; $display("FAIL acc_skid_first got=%h exp=10", amod); end
        out_ready = 1'b1;
        tick();
        $display("tb: acc skid drain amod=%h", amod);
        checks++; if (out_valid !== 1'b1 || amod !== 8'h20) begin
            errors++; $display("FAIL acc_skid_captured got=%b/%h exp=1/20", out_valid, amod);
        end
        tick();
        drive(4'b1010, 8'h00, 8'h00);
        tick();
        in_valid = 1'b0;
        checks++; if (amod !== 8'h30) begin errors++; $display("FAIL acc_latest got=%h exp=30", amod); end
        tick();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(4'b1100, 8'h33, 8'h44);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        $display("tb: illegal amod=%h bmod=%h illegal=%b", amod, bmod, illegal);
        checks++; if (out_valid !== 1'b1 || amod !== 8'h33 || bmod !== 8'h44 || cin !== 1'b0) begin
            errors++; $display("FAIL ill_data got=%b/%h/%h/%b exp=1/33/44/0", out_valid, amod, bmod, cin);
        end
        checks++; if (illegal !== 1'b1 || op_q !== 4'b1100) begin
            errors++; $display("FAIL ill_flag got=%b/%b exp=1/1100", illegal, op_q);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ill_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        acc_wr = 1'b1; acc_din = 8'h7F;
        drive(4'b1011, 8'h11, 8'h22);
        tick();
        acc_wr = 1'b0;
        drive(4'b0010, 8'h55, 8'h66);
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL rf_full got=%b/%b exp=0/1", in_ready, out_valid);
        end
        // Reset must win over a simultaneous accumulator write and request.
        reset = 1'b1; acc_wr = 1'b1; acc_din = 8'h55; out_ready = 1'b1;
        tick();
        reset = 1'b0; acc_wr = 1'b0; in_valid = 1'b0;
        $display("tb: reset while full out_valid=%b in_ready=%b", out_valid, in_ready);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rf_handshake got=%b/%b exp=0/1", out_valid, in_ready);
        end
        checks++; if (amod !== 8'h00 || bmod !== 8'h00 || cin !== 1'b0 || op_q !== 4'h0 || illegal !== 1'b0) begin
            errors++; $display("FAIL rf_outputs got=%h/%h/%b/%h/%b exp=00/00/0/0/0", amod, bmod, cin, op_q, illegal);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_discard got=%b exp=0", out_valid); end
        drive(4'b1010, 8'h12, 8'h05);
        tick();
        in_valid = 1'b0;
        $display("tb: post-reset accadd amod=%h bmod=%h", amod, bmod);
        checks++; if (out_valid !== 1'b1 || amod !== 8'h00 || bmod !== 8'h05) begin
            errors++; $display("FAIL rf_acc_cleared got=%b/%h/%h exp=1/00/05", out_valid, amod, bmod);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_backpressure();
        test_accumulator();
        test_illegal();
        test_reset_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Parametrised, pipelined successor to the ALU operand preprocessing path.
- Maps an opcode plus operands A/B onto adder-ready operands (AMod, BMod, carry-in) and registers them behind a valid/ready handshake with a 2-entry skid buffer.
- Extends the 3-bit op set with subtract, decrement and accumulator-sourced ops; adds an internal accumulator register.
- Sits between operand fetch and the adder/logic unit.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream request valid
- in_ready  output  1  stage can accept; = skid entry empty
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  4  opcode (encodings in package)
- acc_wr  input  1  load accumulator this cycle
- acc_din  input  WIDTH  accumulator load value (ALU result feedback)
- out_valid  output  1  output registers hold a transaction
- out_ready  input  1  downstream accepts
- amod  output  WIDTH  mapped operand A
- bmod  output  WIDTH  mapped operand B
- cin  output  1  adder carry-in
- op_q  output  4  opcode travelling with the operands
- illegal  output  1  op was reserved (11xx)

Behaviour:
- Handshakes: accept when in_valid & in_ready; emit when out_valid & out_ready. in_ready depends only on registered state (skid empty), never combinationally on out_ready.
- Latency: an accepted transaction appears on the outputs the next cycle when the output register is free or draining. FIFO order is preserved at all times.
- Buffering:
  - Output register plus one skid entry.
  - Skid fills only when an accept coincides with a held output (out_valid & ~out_ready).
  - When the output drains, the skid entry moves to the output before any new input.
  - Throughput is 1 transaction/cycle with out_ready high.
- Op mapping (K1 = WIDTH'd 1, ONES = all ones):
  - 0000 PASSA: amod=0, bmod=a, cin=0
  - 0001 NEG: amod=K1, bmod=~a, cin=0
  - 0010 ADD: amod=a, bmod=b, cin=0
  - 0011 INC: amod=K1, bmod=a, cin=0
  - 01xx logic: amod=a, bmod=b, cin=0
  - 1000 SUB: amod=a, bmod=~b, cin=1
  - 1001 DEC: amod=a, bmod=ONES, cin=0
  - 1010 ACCADD: amod=acc, bmod=b, cin=0
  - 1011 ACCSUB: amod=acc, bmod=~b, cin=1
  - 11xx: amod=a, bmod=b, cin=0, illegal=1; the transaction still passes through
- Mapping is computed at acceptance; the skid stores mapped values, not raw operands.
- Accumulator:
  - acc <= acc_din on acc_wr, regardless of handshake state.
  - If an ACC op is accepted in the same cycle as acc_wr, it uses acc_din (forwarding).
  - ACC ops sitting in the skid keep their captured value.
- All arithmetic is modulo 2^WIDTH. No status flags are generated here.
- Reset (synchronous, dominates all other inputs in that cycle):
  - out_valid=0, skid empty (in_ready=1 the cycle after reset), acc=0.
  - amod=0, bmod=0, cin=0, op_q=0, illegal=0.
  - Transactions in flight during reset are discarded.
- Output stability: while out_valid & ~out_ready, amod/bmod/cin/op_q/illegal must not change.

Decomposition:
- Shared package alu_pkg: 4-bit opcode localparams (OP_PASSA..OP_ACCSUB), the reserved-prefix constant 2'b11, and the payload width formula WIDTH*2+6.
- Sub-module operand_map: purely combinational op, a, b, acc → amod, bmod, cin, illegal.
- The top level holds the accumulator, skid entry, output register and handshake control.

Test Plan:
- WIDTH=8, SUB a=0x05 b=0x03, out_ready=1 -> next cycle out_valid=1, amod=0x05, bmod=0xFC, cin=1, op_q=1000.
- NEG a=0x05 -> amod=0x01, bmod=0xFA, cin=0; INC a=0xFF -> amod=0x01, bmod=0xFF.
- Backpressure:
  - out_ready=0, send ADD(1,2) then ADD(3,4) -> in_ready=0 after second accept, third request stalls, outputs stay 0x01/0x02.
  - Raise out_ready -> outputs (1,2), (3,4), third in order, with no gaps.
- Accumulator:
  - acc_wr=1 acc_din=0x10 plus ACCADD b=0x02 in the same cycle -> amod=0x10.
  - Next ACCADD with no write -> amod=0x10.
  - ACCSUB b=0x01 -> bmod=0xFE, cin=1.
- Illegal op=1100 a=0x33 b=0x44 -> amod=0x33, bmod=0x44, illegal=1, handshake completes normally.
- Reset with both entries full and acc=0x7F -> next cycle out_valid=0, in_ready=1, all outputs 0; a following ACCADD yields amod=0x00.
